// File: rtl/gmii_rate_detect_if.sv
// Status bundle published by the GMII rate detector towards the MAC / clock muxes.
`timescale 1ns / 1ps

interface gmii_rate_detect_if #(
  parameter int unsigned CNT_W = 8
);
  logic [1:0]       SPEED;
  logic             GMII_1000M;
  logic             LINK_CLK;
  logic [CNT_W-1:0] RATE_CNT;
  logic             UPDATE;

  modport master (
    output SPEED,
    output GMII_1000M,
    output LINK_CLK,
    output RATE_CNT,
    output UPDATE
  );

  modport slave (
    input SPEED,
    input GMII_1000M,
    input LINK_CLK,
    input RATE_CNT,
    input UPDATE
  );
endinterface

// File: rtl/gmii_rate_detect.sv
// Measures GMII_RX_CLK against CLK_200M over a fixed window, classifies the rate
// and debounces the class before publishing it as SPEED.
// The interface CNT_W must match this module's CNT_W.
`timescale 1ns / 1ps

module gmii_rate_detect #(
  parameter int unsigned WINDOW_CYC = 200,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned TH_1000M   = 64,
  parameter int unsigned TH_100M    = 8,
  parameter int unsigned STABLE_N   = 3,
  parameter int unsigned HOLD_CYC   = 8
) (
  input  logic              CLK_200M,
  input  logic              SYS_RSTn,
  input  logic              GMII_RX_CLK,
  gmii_rate_detect_if.master rate_if
);

  localparam int unsigned TimerW = $clog2(WINDOW_CYC + HOLD_CYC + 1);
  localparam int unsigned AgreeW = $clog2(STABLE_N + 1);

  typedef enum logic [1:0] {StClr, StRun, StHold, StEval} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              cnt_rst_q, cnt_rst_d;
  logic              run_q, run_d;

  // Window sequencer: clear, count, let the count settle, evaluate.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TimerW'(1);
    unique case (state_q)
      StClr: begin
        if (timer_q == TimerW'(1)) begin
          state_d = StRun;
          timer_d = '0;
        end
      end
      StRun: begin
        if (timer_q == TimerW'(WINDOW_CYC - 1)) begin
          state_d = StHold;
          timer_d = '0;
        end
      end
      StHold: begin
        if (timer_q == TimerW'(HOLD_CYC - 1)) begin
          state_d = StEval;
          timer_d = '0;
        end
      end
      StEval: begin
        state_d = StClr;
        timer_d = '0;
      end
      default: begin
        state_d = StClr;
        timer_d = '0;
      end
    endcase
    // Registered controls follow the state they belong to, glitch-free for the RX domain.
    cnt_rst_d = (state_d == StClr);
    run_d     = (state_d == StRun);
  end

  // Sequencer state register.
  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      state_q   <= StClr;
      timer_q   <= '0;
      cnt_rst_q <= 1'b1;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cnt_rst_q <= cnt_rst_d;
      run_q     <= run_d;
    end
  end

  logic             run_meta_q, run_sync_q;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;

  // Saturating edge counter, enabled by the synchronized RUN.
  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (run_sync_q && (rx_cnt_q != '1)) begin
      rx_cnt_d = rx_cnt_q + CNT_W'(1);
    end
  end

  // RX-domain flops; CNT_RST is their only reset so an absent RX clock still reads 0.
  always_ff @(posedge GMII_RX_CLK or posedge cnt_rst_q) begin
    if (cnt_rst_q) begin
      run_meta_q <= 1'b0;
      run_sync_q <= 1'b0;
      rx_cnt_q   <= '0;
    end else begin
      run_meta_q <= run_q;
      run_sync_q <= run_meta_q;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  logic [CNT_W-1:0] cnt_meta_q, cnt_sync_q;

  // Bitwise count synchronizer; the count is frozen well before S_EVAL reads it.
  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      cnt_meta_q <= '0;
      cnt_sync_q <= '0;
    end else begin
      cnt_meta_q <= rx_cnt_q;
      cnt_sync_q <= cnt_meta_q;
    end
  end

  logic [1:0]        cls;
  logic [1:0]        speed_q, speed_d, pend_q, pend_d;
  logic [AgreeW-1:0] agree_q, agree_d, agree_inc;
  logic [CNT_W-1:0]  rate_cnt_q, rate_cnt_d;
  logic              update_q, update_d;
  logic              gmii_1000m_q, gmii_1000m_d;
  logic              link_clk_q, link_clk_d;

  // Classify the window count and debounce the class into SPEED.
  always_comb begin
    cls = 2'b00;
    if (cnt_sync_q >= CNT_W'(TH_1000M)) begin
      cls = 2'b11;
    end else if (cnt_sync_q >= CNT_W'(TH_100M)) begin
      cls = 2'b10;
    end else if (cnt_sync_q != '0) begin
      cls = 2'b01;
    end

    speed_d    = speed_q;
    pend_d     = pend_q;
    agree_d    = agree_q;
    agree_inc  = agree_q + AgreeW'(1);
    rate_cnt_d = rate_cnt_q;
    update_d   = 1'b0;

    if (state_q == StEval) begin
      rate_cnt_d = cnt_sync_q;
      if (cls == speed_q) begin
        agree_d = '0;
      end else if (cls == pend_q) begin
        if (agree_inc == AgreeW'(STABLE_N)) begin
          speed_d  = cls;
          update_d = 1'b1;
          agree_d  = '0;
        end else begin
          agree_d = agree_inc;
        end
      end else begin
        pend_d  = cls;
        agree_d = AgreeW'(1);
        if (STABLE_N == 1) begin
          speed_d  = cls;
          update_d = 1'b1;
          agree_d  = '0;
        end
      end
    end

    gmii_1000m_d = (speed_d == 2'b11);
    link_clk_d   = (speed_d != 2'b00);
  end

  // Debounce and output registers.
  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      speed_q      <= 2'b00;
      pend_q       <= 2'b00;
      agree_q      <= '0;
      rate_cnt_q   <= '0;
      update_q     <= 1'b0;
      gmii_1000m_q <= 1'b0;
      link_clk_q   <= 1'b0;
    end else begin
      speed_q      <= speed_d;
      pend_q       <= pend_d;
      agree_q      <= agree_d;
      rate_cnt_q   <= rate_cnt_d;
      update_q     <= update_d;
      gmii_1000m_q <= gmii_1000m_d;
      link_clk_q   <= link_clk_d;
    end
  end

  assign rate_if.SPEED      = speed_q;
  assign rate_if.GMII_1000M = gmii_1000m_q;
  assign rate_if.LINK_CLK   = link_clk_q;
  assign rate_if.RATE_CNT   = rate_cnt_q;
  assign rate_if.UPDATE     = update_q;

endmodule

// File: tb/tb_gmii_rate_detect.sv
// Bench for gmii_rate_detect: drives RX clocks of known frequency, one rate per
// window, and compares against a history-based model of the debounced class.
`timescale 1ns / 1ps

module tb_gmii_rate_detect;

  localparam int unsigned CntW    = 8;
  localparam int          StableN = 3;
  localparam int          Period  = 200 + 8 + 3;

  // Rate codes used by the stimulus.
  localparam int RNone = 0;
  localparam int R2m5  = 1;
  localparam int R25m  = 2;
  localparam int R125m = 3;
  localparam int R300m = 4;

  logic clk_200m = 1'b0;
  logic sys_rstn = 1'b1;
  logic rx_clk   = 1'b0;

  gmii_rate_detect_if #(.CNT_W(CntW)) rate_if ();

  gmii_rate_detect #(
    .WINDOW_CYC(200),
    .CNT_W     (CntW),
    .TH_1000M  (64),
    .TH_100M   (8),
    .STABLE_N  (StableN),
    .HOLD_CYC  (8)
  ) dut (
    .CLK_200M   (clk_200m),
    .SYS_RSTn   (sys_rstn),
    .GMII_RX_CLK(rx_clk),
    .rate_if    (rate_if)
  );

  always #2.5 clk_200m = ~clk_200m;

  int checks    = 0;
  int failures  = 0;
  int upd_total = 0;

  always @(negedge clk_200m) begin
    if (rate_if.UPDATE) upd_total++;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // RX clock generator; restarting it re-phases the clock at the start of a window.
  real rx_half = 0.0;
  real rx_off  = 0.0;
  int  rx_gen  = 0;

  initial begin : rx_gen_p
    forever begin
      int  my_gen;
      real rem;
      my_gen = rx_gen;
      rx_clk = 1'b0;
      #(rx_off);
      while (my_gen == rx_gen) begin
        if (rx_half == 0.0) begin
          wait (rx_gen != my_gen);
        end else begin
          rem = rx_half;
          while (rem > 0.0 && my_gen == rx_gen) begin
            if (rem > 4.0) begin
              #4;
              rem = rem - 4.0;
            end else begin
              #(rem);
              rem = 0.0;
            end
          end
          if (my_gen == rx_gen) rx_clk = ~rx_clk;
        end
      end
    end
  end

  function automatic real half_of(input int r);
    case (r)
      R2m5:    return 200.0;
      R25m:    return 20.0;
      R125m:   return 4.0;
      R300m:   return 1.6667;
      default: return 0.0;
    endcase
  endfunction

  // Nominal class from frequency: >=64 edges/us is 1000M, >=8 is 100M, any edge is 10M.
  function automatic int class_of(input int r);
    case (r)
      R2m5:          return 1;
      R25m:          return 2;
      R125m, R300m:  return 3;
      default:       return 0;
    endcase
  endfunction

  task automatic count_range(input int r, output int lo, output int hi);
    case (r)
      R2m5:    begin lo = 1;   hi = 4;   end
      R25m:    begin lo = 23;  hi = 27;  end
      R125m:   begin lo = 123; hi = 127; end
      R300m:   begin lo = 255; hi = 255; end
      default: begin lo = 0;   hi = 0;   end
    endcase
  endtask

  // Reference debounce: SPEED moves once the last StableN classes agree and differ from it.
  int m_speed = 0;
  int hist[$];

  task automatic model_step(input int cls, output int upd);
    bit same;
    upd = 0;
    hist.push_back(cls);
    if (hist.size() > StableN) void'(hist.pop_front());
    if (hist.size() == StableN && cls != m_speed) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != cls) same = 1'b0;
      if (same) begin
        m_speed = cls;
        upd     = 1;
      end
    end
  endtask

  task automatic model_reset();
    m_speed = 0;
    hist.delete();
  endtask

  task automatic set_rate(input int r);
    rx_half = half_of(r);
    rx_off  = real'($urandom_range(0, 10));
    rx_gen++;
  endtask

  task automatic check_outputs_zero(input string name);
    check_eq({name, " SPEED"}, int'(rate_if.SPEED), 0);
    check_eq({name, " GMII_1000M"}, int'(rate_if.GMII_1000M), 0);
    check_eq({name, " LINK_CLK"}, int'(rate_if.LINK_CLK), 0);
    check_eq({name, " RATE_CNT"}, int'(rate_if.RATE_CNT), 0);
    check_eq({name, " UPDATE"}, int'(rate_if.UPDATE), 0);
  endtask

  // Called just after the cycle that published the previous evaluation (or reset release).
  task automatic run_window(input int r, input string name);
    int lo, hi, cnt, upd0, exp_upd;
    set_rate(r);
    upd0 = upd_total;
    repeat (Period) @(posedge clk_200m);
    @(negedge clk_200m);
    #1;
    model_step(class_of(r), exp_upd);
    count_range(r, lo, hi);
    cnt = int'(rate_if.RATE_CNT);
    check_eq($sformatf("%s rate_cnt=%0d within %0d..%0d", name, cnt, lo, hi),
             int'(cnt >= lo && cnt <= hi), 1);
    check_eq({name, " SPEED"}, int'(rate_if.SPEED), m_speed);
    check_eq({name, " GMII_1000M"}, int'(rate_if.GMII_1000M), int'(m_speed == 3));
    check_eq({name, " LINK_CLK"}, int'(rate_if.LINK_CLK), int'(m_speed != 0));
    check_eq({name, " UPDATE"}, int'(rate_if.UPDATE), exp_upd);
    check_eq({name, " update_pulses"}, upd_total - upd0, exp_upd);
  endtask

  initial begin
    set_rate(RNone);
    #1 sys_rstn = 1'b0;
    repeat (5) @(posedge clk_200m);
    #1;
    check_outputs_zero("reset");
    @(negedge clk_200m);
    sys_rstn = 1'b1;
    #1;
    model_reset();

    for (int i = 0; i < 3; i++) run_window(R125m, $sformatf("lock125_w%0d", i));
    for (int i = 0; i < 3; i++) run_window(RNone, $sformatf("stop_w%0d", i));
    for (int i = 0; i < 3; i++) run_window(R25m, $sformatf("r25_w%0d", i));
    for (int i = 0; i < 3; i++) run_window(R2m5, $sformatf("r2m5_w%0d", i));
    for (int i = 0; i < 3; i++) run_window(R125m, $sformatf("relock_w%0d", i));
    for (int i = 0; i < 6; i++) begin
      run_window((i % 2 == 0) ? R25m : R125m, $sformatf("alt_w%0d", i));
    end
    for (int i = 0; i < 3; i++) run_window(R300m, $sformatf("sat_w%0d", i));

    // Reset pulse partway through a counting window while locked at 1000M.
    set_rate(R125m);
    repeat (2 + $urandom_range(10, 150)) @(posedge clk_200m);
    #1 sys_rstn = 1'b0;
    #1;
    check_outputs_zero("midrun_reset");
    repeat ($urandom_range(2, 6)) @(posedge clk_200m);
    @(negedge clk_200m);
    sys_rstn = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) run_window(R125m, $sformatf("post_reset_w%0d", i));

    // Random bursts of rates so the debounce sees both settled and interrupted runs.
    for (int b = 0; b < 25; b++) begin
      int r, len;
      r   = $urandom_range(0, 4);
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) run_window(r, $sformatf("rnd_b%0d_r%0d_w%0d", b, r, i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gmii_rate_detect.md
GMII_RATE_DETECT -- requirements
Module: gmii_rate_detect

Interface
REQ-001 Parameter WINDOW_CYC, default 200: count-window length in CLK_200M cycles.
REQ-002 Parameter CNT_W, default 8: width of the RX-clock edge counter; CNT_W SHALL be at least 2.
REQ-003 Parameter TH_1000M, default 64: minimum count that classifies the link as 1000M.
REQ-004 Parameter TH_100M, default 8: minimum count that classifies the link as 100M; TH_100M SHALL be less than TH_1000M.
REQ-005 Parameter STABLE_N, default 3: number of consecutive agreeing windows required before SPEED changes; STABLE_N SHALL be at least 1.
REQ-006 Parameter HOLD_CYC, default 8: freeze/settle time in CLK_200M cycles; HOLD_CYC SHALL be at least 6.
REQ-007 CLK_200M  in  1  system clock.
REQ-008 SYS_RSTn  in  1  reset; the reset is asynchronous, active-low, and the clock is CLK_200M.
REQ-009 GMII_RX_CLK  in  1  PHY receive clock under measurement (2.5, 25 or 125 MHz, or absent).
REQ-010 SPEED  out  2  debounced rate class: 00 = no clock, 01 = 10M, 10 = 100M, 11 = 1000M.
REQ-011 GMII_1000M  out  1  high when SPEED = 11; drives the MAC GMII/MII mode select and the TX clock mux select.
REQ-012 LINK_CLK  out  1  high when SPEED is not 00.
REQ-013 RATE_CNT  out  CNT_W  raw count captured in the most recent window.
REQ-014 UPDATE  out  1  one-cycle pulse whenever SPEED changes.

Function
REQ-015 The sequencer SHALL be in the CLK_200M domain and cycle S_CLR(2) -> S_RUN(WINDOW_CYC) -> S_HOLD(HOLD_CYC) -> S_EVAL(1) -> S_CLR; numbers in brackets are cycles per state; default period is 211 cycles.
REQ-016 CNT_RST SHALL be a registered output, high only in S_CLR, and SHALL asynchronously clear the RX-domain counter.
REQ-017 RUN SHALL be a registered output, high only in S_RUN, and SHALL cross to GMII_RX_CLK through a 2-flop synchronizer.
REQ-018 The RX-domain counter SHALL increment on each GMII_RX_CLK rising edge while synchronized RUN is high.
REQ-019 The counter SHALL saturate at all-ones and never wrap.
REQ-020 The counter SHALL hold its value while synchronized RUN is low.
REQ-021 Counter bits SHALL be sampled into CLK_200M through 2-flop synchronizers; the value is static during the last 4 cycles of S_HOLD, so no multi-bit skew occurs.
REQ-022 With GMII_RX_CLK absent, the counter SHALL remain 0 (cleared in S_CLR, never enabled).
REQ-023 In S_EVAL, RATE_CNT SHALL load the synchronized count.
REQ-024 In S_EVAL, the class SHALL be: count >= TH_1000M -> 11; else count >= TH_100M -> 10; else count >= 1 -> 01; else 00.
REQ-025 Debounce, class equal to SPEED: the agree counter clears and PEND is unchanged.
REQ-026 Debounce, class not equal to SPEED and equal to PEND: the agree counter increments; on reaching STABLE_N, SPEED takes the class, UPDATE pulses one cycle, and the agree counter clears.
REQ-027 Debounce, class not equal to SPEED and not equal to PEND: PEND takes the class and the agree counter is set to 1; if STABLE_N = 1, SPEED takes the class immediately and UPDATE pulses.
REQ-028 GMII_1000M and LINK_CLK SHALL be registered and update in the same cycle as SPEED.
REQ-029 Loss of clock SHALL be debounced identically to any other class change; there is no fast path.
REQ-030 A sub-window glitch or stopped RX clock SHALL only affect classification through the window count.
REQ-031 Latency from a stable new rate to the SPEED change SHALL be at most (STABLE_N+1) window periods.

Reset
REQ-032 While SYS_RSTn is low: state = S_CLR, CNT_RST = 1, RUN = 0, SPEED = 00, PEND = 00, agree counter = 0, RATE_CNT = 0, GMII_1000M = 0, LINK_CLK = 0, UPDATE = 0.
REQ-033 The RX-domain synchronizer and counter SHALL be cleared via CNT_RST; no RX-domain reset is needed beyond CNT_RST.
REQ-034 Reset asserted mid-window SHALL abort the window; the first S_EVAL after release SHALL use a fully fresh count.

Verification
REQ-035 125 MHz RX clock from reset -> RATE_CNT in 123..127 each window; SPEED = 11, GMII_1000M = 1 and a single UPDATE pulse at the 3rd S_EVAL.
REQ-036 25 MHz -> RATE_CNT in 23..27; SPEED = 10 after 3 windows. 2.5 MHz -> RATE_CNT in 1..4; SPEED = 01 after 3 windows.
REQ-037 Locked at 1000M, then RX clock stopped -> SPEED stays 11 for 2 evaluations, goes to 00 on the 3rd; LINK_CLK = 0 and GMII_1000M = 0 at the same time.
REQ-038 Rate alternating 125 MHz/25 MHz each window after lock at 11 -> SPEED never changes; UPDATE never pulses.
REQ-039 300 MHz RX clock -> RATE_CNT = 255 (saturated, no wrap); SPEED = 11.
REQ-040 SYS_RSTn pulsed low during S_RUN while at 1000M -> all outputs 0 within the reset; relock to 11 after 3 full windows.
